// File: rtl/data_memory_pkg.sv
// Shared types and constants for the two-requester data memory arbiter.
package data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;

    localparam int unsigned DEFAULT_MEM_DEPTH = 256;

    // Full 32-bit unsigned compare so wrap-around addresses such as 0xFFFFFFFF are caught.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned depth);
        return addr >= 32'(depth);
    endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester handshake and memory pin bundle around the data memory arbiter.
interface data_memory_arbiter_if;
    logic        req0_in,   req1_in;
    logic        write0_in, write1_in;
    logic [31:0] addr0_in,  addr1_in;
    logic [31:0] data0_in,  data1_in;
    logic        ack0_out,  ack1_out;
    logic [31:0] rdata_out;
    logic        err_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_data_out;
    logic        mem_write_out;
    logic [31:0] mem_data_in;
    logic        busy_out;

    modport slave (
        input  req0_in, req1_in, write0_in, write1_in,
        input  addr0_in, addr1_in, data0_in, data1_in, mem_data_in,
        output ack0_out, ack1_out, rdata_out, err_out,
        output mem_addr_out, mem_data_out, mem_write_out, busy_out
    );

    modport master (
        output req0_in, req1_in, write0_in, write1_in,
        output addr0_in, addr1_in, data0_in, data1_in, mem_data_in,
        input  ack0_out, ack1_out, rdata_out, err_out,
        input  mem_addr_out, mem_data_out, mem_write_out, busy_out
    );
endinterface

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
// Combinational two-way arbiter; the caller owns the last-grant register.
module rr_arbiter_2
    import data_memory_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic grant_valid_o
);

    always_comb begin
        grant_valid_o = req0_i | req1_i;
        grant_o       = REQ_CPU;
        if (req0_i && req1_i) begin
            grant_o = ROUND_ROBIN ? ~last_grant_i : REQ_CPU;
        end else if (req1_i) begin
            grant_o = REQ_DBG;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the CPU and debug requesters,
// one IDLE -> ACCESS -> RESP transaction at a time with registered memory command.
module data_memory_arbiter
    import data_memory_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = DEFAULT_MEM_DEPTH,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    data_memory_arbiter_if.slave  bus
);

    state_e      state_q;
    logic        last_grant_q;
    logic        winner_q;
    logic        is_write_q;
    logic        range_err_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_data_q;
    logic        mem_write_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        ack0_q;
    logic        ack1_q;

    logic        grant;
    logic        grant_valid;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_data_d;
    logic        sel_write_d;
    logic        range_err_d;

    rr_arbiter_2 #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_arb (
        .req0_i        (bus.req0_in),
        .req1_i        (bus.req1_in),
        .last_grant_i  (last_grant_q),
        .grant_o       (grant),
        .grant_valid_o (grant_valid)
    );

    always_comb begin
        sel_addr_d  = (grant == REQ_DBG) ? bus.addr1_in  : bus.addr0_in;
        sel_data_d  = (grant == REQ_DBG) ? bus.data1_in  : bus.data0_in;
        sel_write_d = (grant == REQ_DBG) ? bus.write1_in : bus.write0_in;
        range_err_d = addr_out_of_range(sel_addr_d, MEM_DEPTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_DBG;
            winner_q     <= REQ_CPU;
            is_write_q   <= 1'b0;
            range_err_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_write_q  <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_valid) begin
                        mem_addr_q   <= sel_addr_d;
                        mem_data_q   <= sel_data_d;
                        winner_q     <= grant;
                        is_write_q   <= sel_write_d;
                        range_err_q  <= range_err_d;
                        // Out-of-range stores never reach the memory write pin.
                        mem_write_q  <= sel_write_d & ~range_err_d;
                        last_grant_q <= grant;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q     <= (range_err_q || is_write_q) ? '0 : bus.mem_data_in;
                    err_q       <= range_err_q;
                    ack0_q      <= (winner_q == REQ_CPU);
                    ack1_q      <= (winner_q == REQ_DBG);
                    mem_write_q <= 1'b0;
                    state_q     <= RESP;
                end
                RESP: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr_out  = mem_addr_q;
    assign bus.mem_data_out  = mem_data_q;
    assign bus.mem_write_out = mem_write_q;
    assign bus.rdata_out     = rdata_q;
    assign bus.err_out       = err_q;
    assign bus.ack0_out      = ack0_q;
    assign bus.ack1_out      = ack1_q;
    assign bus.busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus randomized traffic
// checked against a word-array memory model and round-robin bookkeeping.
module tb_data_memory_arbiter;

    logic clk;
    logic rst_n;

    data_memory_arbiter_if bus();
    data_memory_arbiter_if bus_fp();

    data_memory_arbiter #(.MEM_DEPTH(256), .ROUND_ROBIN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    data_memory_arbiter #(.MEM_DEPTH(256), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fp.slave)
    );

    // Physical memory: address bits above 7 are ignored, so unsuppressed
    // out-of-range stores would visibly alias onto low words.
    logic [31:0] mem [256];
    logic [31:0] exp_mem [256];

    assign bus.mem_data_in    = mem[bus.mem_addr_out[7:0]];
    assign bus_fp.mem_data_in = 32'h0;

    always @(posedge clk) begin
        if (bus.mem_write_out) mem[bus.mem_addr_out[7:0]] = bus.mem_data_out;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_last;

    int          t_lat;
    int          t_wrhi;
    logic        t_other;
    logic [31:0] t_rd;
    logic        t_er;
    logic [31:0] t_rd_after;
    logic        t_after;

    // Drives one transaction from requester r starting at a negedge while idle.
    task automatic run_txn(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
        t_lat = -1; t_wrhi = 0; t_other = 1'b0;
        if (r == 0) begin
            bus.req0_in = 1'b1; bus.write0_in = w; bus.addr0_in = a; bus.data0_in = d;
        end else begin
            bus.req1_in = 1'b1; bus.write1_in = w; bus.addr1_in = a; bus.data1_in = d;
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.mem_write_out) t_wrhi++;
            if ((r == 0 && bus.ack1_out) || (r == 1 && bus.ack0_out)) t_other = 1'b1;
            if ((r == 0) ? bus.ack0_out : bus.ack1_out) begin
                t_lat = c;
                break;
            end
        end
        t_rd = bus.rdata_out;
        t_er = bus.err_out;
        bus.req0_in = 1'b0; bus.req1_in = 1'b0;
        @(posedge clk); @(negedge clk);
        t_rd_after = bus.rdata_out;
        t_after    = bus.ack0_out | bus.ack1_out | bus.err_out | bus.busy_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req0_in = 0; bus.req1_in = 0; bus.write0_in = 0; bus.write1_in = 0;
        bus.addr0_in = 0; bus.addr1_in = 0; bus.data0_in = 0; bus.data1_in = 0;
        bus_fp.req0_in = 0; bus_fp.req1_in = 0; bus_fp.write0_in = 0; bus_fp.write1_in = 0;
        bus_fp.addr0_in = 0; bus_fp.addr1_in = 0; bus_fp.data0_in = 0; bus_fp.data1_in = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'hC0DE0000 | 32'(i);
            exp_mem[i] = 32'hC0DE0000 | 32'(i);
        end
        exp_last = 1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.ack0_out, bus.ack1_out, bus.err_out, bus.mem_write_out, bus.busy_out} !== 5'b0)
            begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                {bus.ack0_out, bus.ack1_out, bus.err_out, bus.mem_write_out, bus.busy_out}); end
        n_cmp++;
        if ({bus.rdata_out, bus.mem_addr_out, bus.mem_data_out} !== 96'h0)
            begin n_fail++; $display("FAIL reset_data: got %h/%h/%h expected 0",
                bus.rdata_out, bus.mem_addr_out, bus.mem_data_out); end
    endtask

    task automatic test_store();
        run_txn(0, 1'b1, 32'd5, 32'hDEADBEEF);
        exp_mem[5] = 32'hDEADBEEF; exp_last = 0;
        n_cmp++; if (t_lat !== 2) begin n_fail++; $display("FAIL store_latency: got %0d expected 2", t_lat); end
        n_cmp++; if (t_wrhi !== 1) begin n_fail++; $display("FAIL store_write_cycles: got %0d expected 1", t_wrhi); end
        n_cmp++; if (t_er !== 1'b0) begin n_fail++; $display("FAIL store_err: got %b expected 0", t_er); end
        n_cmp++; if (mem[5] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_mem5: got %h expected deadbeef", mem[5]); end
        n_cmp++; if (t_after !== 1'b0) begin n_fail++; $display("FAIL store_ack_drop: got %b expected 0", t_after); end
    endtask

    task automatic test_load();
        run_txn(1, 1'b0, 32'd5, 32'h0);
        exp_last = 1;
        n_cmp++; if (t_lat !== 2) begin n_fail++; $display("FAIL load_latency: got %0d expected 2", t_lat); end
        n_cmp++; if (t_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", t_rd); end
        n_cmp++; if (t_er !== 1'b0 || t_other !== 1'b0) begin n_fail++; $display("FAIL load_err_other: got %b%b expected 00", t_er, t_other); end
        n_cmp++; if (t_rd_after !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_hold: got %h expected deadbeef", t_rd_after); end
    endtask

    task automatic test_round_robin();
        int ids[$];
        int cyc[$];
        int first;
        first = (exp_last == 0) ? 1 : 0;
        bus.req0_in = 1; bus.write0_in = 0; bus.addr0_in = 32'd5;
        bus.req1_in = 1; bus.write1_in = 0; bus.addr1_in = 32'd255;
        for (int c = 1; c <= 30 && ids.size() < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.ack0_out && bus.ack1_out) begin
                n_cmp++; n_fail++; $display("FAIL rr_double_ack: got 11 expected one-hot at cycle %0d", c);
            end else if (bus.ack0_out) begin ids.push_back(0); cyc.push_back(c); end
            else if (bus.ack1_out) begin ids.push_back(1); cyc.push_back(c); end
        end
        bus.req0_in = 0; bus.req1_in = 0;
        n_cmp++; if (ids.size() !== 6) begin n_fail++; $display("FAIL rr_ack_count: got %0d expected 6", ids.size()); end
        for (int i = 0; i < ids.size(); i++) begin
            n_cmp++;
            if (ids[i] !== (first + i) % 2) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, ids[i], (first + i) % 2); end
            if (i > 0) begin
                n_cmp++;
                if (cyc[i] - cyc[i-1] !== 3) begin n_fail++; $display("FAIL rr_spacing[%0d]: got %0d expected 3", i, cyc[i] - cyc[i-1]); end
            end
        end
        if (ids.size() > 0) exp_last = ids[ids.size()-1];
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_range();
        logic [31:0] m0;
        logic [31:0] m255;
        m0 = mem[0]; m255 = mem[255];
        run_txn(0, 1'b1, 32'd256, 32'hA5A5A5A5);
        n_cmp++; if (t_er !== 1'b1 || t_rd !== 32'h0 || t_lat !== 2) begin n_fail++; $display("FAIL range256_resp: got err=%b rd=%h lat=%0d expected 1/0/2", t_er, t_rd, t_lat); end
        n_cmp++; if (t_wrhi !== 0 || mem[0] !== m0) begin n_fail++; $display("FAIL range256_nowrite: got wr=%0d mem0=%h expected 0/%h", t_wrhi, mem[0], m0); end
        run_txn(1, 1'b1, 32'hFFFFFFFF, 32'h5A5A5A5A);
        n_cmp++; if (t_er !== 1'b1 || t_rd !== 32'h0) begin n_fail++; $display("FAIL rangeFFFF_resp: got err=%b rd=%h expected 1/0", t_er, t_rd); end
        n_cmp++; if (t_wrhi !== 0 || mem[255] !== m255) begin n_fail++; $display("FAIL rangeFFFF_nowrite: got wr=%0d mem255=%h expected 0/%h", t_wrhi, mem[255], m255); end
        run_txn(0, 1'b1, 32'd255, 32'h12345678);
        exp_mem[255] = 32'h12345678;
        n_cmp++; if (t_er !== 1'b0 || t_wrhi !== 1 || mem[255] !== 32'h12345678) begin n_fail++; $display("FAIL range255_store: got err=%b wr=%0d mem=%h expected 0/1/12345678", t_er, t_wrhi, mem[255]); end
        run_txn(0, 1'b0, 32'd256, 32'h0);
        exp_last = 0;
        n_cmp++; if (t_er !== 1'b1 || t_rd !== 32'h0) begin n_fail++; $display("FAIL range256_load: got err=%b rd=%h expected 1/0", t_er, t_rd); end
    endtask

    task automatic test_reset_mid_access();
        int acks;
        logic got0;
        acks = 0;
        bus.req0_in = 1; bus.write0_in = 1; bus.addr0_in = 32'd7; bus.data0_in = 32'hBAD0BAD0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (bus.mem_write_out !== 1'b1) begin n_fail++; $display("FAIL rst_pre_write: got %b expected 1", bus.mem_write_out); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_write_out !== 1'b0 || bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_async_clear: got wr=%b busy=%b expected 0/0", bus.mem_write_out, bus.busy_out); end
        bus.req0_in = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.ack0_out || bus.ack1_out) acks++;
        end
        n_cmp++; if (acks !== 0 || mem[7] !== exp_mem[7]) begin n_fail++; $display("FAIL rst_no_commit: got acks=%0d mem7=%h expected 0/%h", acks, mem[7], exp_mem[7]); end
        rst_n = 1'b1;
        @(negedge clk);
        bus.req0_in = 1; bus.write0_in = 0; bus.addr0_in = 32'd7;
        bus.req1_in = 1; bus.write1_in = 0; bus.addr1_in = 32'd5;
        got0 = 1'b0; t_rd = 32'h0; acks = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.ack0_out || bus.ack1_out) begin got0 = bus.ack0_out; t_rd = bus.rdata_out; acks = c; break; end
        end
        bus.req0_in = 0; bus.req1_in = 0;
        exp_last = 0;
        n_cmp++; if (got0 !== 1'b1 || acks !== 2) begin n_fail++; $display("FAIL rst_fresh_winner: got ack0=%b lat=%0d expected 1/2", got0, acks); end
        n_cmp++; if (t_rd !== exp_mem[7]) begin n_fail++; $display("FAIL rst_fresh_rdata: got %h expected %h", t_rd, exp_mem[7]); end
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_drop_req();
        int a0;
        int a1;
        a0 = 0; a1 = 0;
        bus.req0_in = 1; bus.write0_in = 0; bus.addr0_in = 32'd5;
        @(posedge clk); @(negedge clk);
        bus.req0_in = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus.ack0_out) a0++;
            if (bus.ack1_out) a1++;
        end
        exp_last = 0;
        n_cmp++; if (a0 !== 1 || a1 !== 0) begin n_fail++; $display("FAIL drop_ack: got ack0=%0d ack1=%0d expected 1/0", a0, a1); end
        n_cmp++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL drop_no_regrant: got busy=%b expected 0", bus.busy_out); end
    endtask

    task automatic test_random();
        int r;
        int sel;
        int diffs;
        logic w;
        logic oob;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        for (int n = 0; n < 40; n++) begin
            r   = int'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            a   = (sel == 0) ? 32'hFFFFFFFF : (sel == 1) ? 32'd256 + $urandom_range(0, 1000) : $urandom_range(0, 255);
            d   = $urandom;
            oob = (a >= 32'd256);
            exp_rd = (w || oob) ? 32'h0 : exp_mem[a[7:0]];
            if (w && !oob) exp_mem[a[7:0]] = d;
            run_txn(r, w, a, d);
            exp_last = r;
            n_cmp++;
            if (t_lat !== 2 || t_rd !== exp_rd || t_er !== oob || t_other !== 1'b0)
                begin n_fail++; $display("FAIL rand[%0d] r=%0d w=%b a=%h: got lat=%0d rd=%h err=%b other=%b expected 2/%h/%b/0",
                    n, r, w, a, t_lat, t_rd, t_er, t_other, exp_rd, oob); end
        end
        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diffs++;
        n_cmp++; if (diffs !== 0) begin n_fail++; $display("FAIL rand_mem_image: got %0d differing words expected 0", diffs); end
    endtask

    task automatic test_fixed_priority();
        int a0;
        int a1;
        a0 = 0; a1 = 0;
        bus_fp.req0_in = 1; bus_fp.addr0_in = 32'd1;
        bus_fp.req1_in = 1; bus_fp.addr1_in = 32'd2;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus_fp.ack0_out) a0++;
            if (bus_fp.ack1_out) a1++;
        end
        bus_fp.req0_in = 0;
        n_cmp++; if (a0 !== 5 || a1 !== 0) begin n_fail++; $display("FAIL fp_only_req0: got ack0=%0d ack1=%0d expected 5/0", a0, a1); end
        a1 = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (bus_fp.ack1_out) a1++;
        end
        bus_fp.req1_in = 0;
        n_cmp++; if (a1 < 1) begin n_fail++; $display("FAIL fp_req1_after_release: got ack1=%0d expected >=1", a1); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_round_robin();
        test_range();
        test_reset_mid_access();
        test_drop_req();
        test_random();
        test_fixed_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
